// File: rtl/spin_pos_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// spin_pos_sequencer_pkg
//   Shared constants for the LED spinner position sequencer: the default
//   number of spinner positions, the width of the position bus that feeds
//   the segment driver, and the encoding of the direction input.
//   No ports (package only).
// ----------------------------------------------------------------------------
package spin_pos_sequencer_pkg;

    // Default number of spinner positions (legal range 2..8).
    localparam int SPIN_NUM_POS = 6;

    // The segment driver takes a 3-bit position index.
    localparam int POS_W = 3;

    // Direction input encoding.
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage : spin_pos_sequencer_pkg

// File: rtl/spin_pos_sequencer_tick_gen.sv
// ----------------------------------------------------------------------------
// spin_pos_sequencer_tick_gen
//   Programmable prescaler. While enabled it counts down from period-1 and
//   raises a one-cycle tick when the count reaches zero, then reloads. The
//   period is max(BASE_DIV >> speed_i, 1), so a new speed only takes effect
//   at the next reload and a running count is never truncated.
//
// Ports
//   clk_i    in   1   system clock
//   rst_i    in   1   synchronous reset, active-high
//   en_i     in   1   1 = count, 0 = hold the counter at its reload value
//   speed_i  in   2   rate select
//   tick_o   out  1   high for the cycle in which the counter sits at zero
// ----------------------------------------------------------------------------
module spin_pos_sequencer_tick_gen
    import spin_pos_sequencer_pkg::*;
#(
    parameter int DIV_W    = 20,
    parameter int BASE_DIV = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] speed_i,
    output logic       tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] reloadVal;

    // Reload value is period-1; a shifted-out period is clamped to 1 so the
    // fastest setting ticks every cycle instead of stalling.
    function automatic logic [DIV_W-1:0] periodMinusOne(input logic [1:0] speed);
        logic [DIV_W-1:0] period;
        period = DIV_W'(BASE_DIV) >> speed;
        if (period == '0) begin
            period = DIV_W'(1);
        end
        return period - DIV_W'(1);
    endfunction

    // Current reload value tracks speed_i combinationally; it is only
    // written into the counter at a reload point.
    always_comb begin
        reloadVal = periodMinusOne(speed_i);
    end

    // The tick is decoded from the current count so that the position
    // register advances on the same edge that reloads the counter.
    assign tick_o = en_i && (cnt_q == '0);

    // Next count: hold at reload while disabled, reload after a tick,
    // otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || (cnt_q == '0)) begin
            cnt_d = reloadVal;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter register; reset loads the reload value for the current speed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= reloadVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : spin_pos_sequencer_tick_gen

// File: rtl/spin_pos_sequencer.sv
// ----------------------------------------------------------------------------
// spin_pos_sequencer
//   Rotating position index for the LED spinner. Steps the position through
//   0..NUM_POS-1 forward or backward, either at the prescaler rate or one
//   step per rising edge of step_i while free-running is disabled.
//
// Ports
//   clk_i    in   1   system clock
//   rst_i    in   1   synchronous reset, active-high, overrides everything
//   en_i     in   1   1 = free-running, 0 = hold / manual single-step
//   dir_i    in   1   0 = forward, 1 = reverse (sampled on the advancing edge)
//   speed_i  in   2   rate select, period = max(BASE_DIV >> speed_i, 1)
//   step_i   in   1   manual step request, rising edge used
//   pos_o    out  3   current position
//   step_o   out  1   one-cycle pulse registered with each position change
//   wrap_o   out  1   one-cycle pulse on the wrapping transition
// ----------------------------------------------------------------------------
module spin_pos_sequencer
    import spin_pos_sequencer_pkg::*;
#(
    parameter int NUM_POS  = SPIN_NUM_POS,
    parameter int DIV_W    = 20,
    parameter int BASE_DIV = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [1:0]       speed_i,
    input  logic             step_i,
    output logic [POS_W-1:0] pos_o,
    output logic             step_o,
    output logic             wrap_o
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);

    logic             tick;
    logic             mstep;
    logic             advance;
    logic             stepReq_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             wrap_d;
    logic             stepPulse_q;
    logic             wrapPulse_q;

    spin_pos_sequencer_tick_gen #(
        .DIV_W    (DIV_W),
        .BASE_DIV (BASE_DIV)
    ) u_tickGen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .speed_i (speed_i),
        .tick_o  (tick)
    );

    // A manual step is a rising edge of step_i, honoured only while the
    // prescaler is disabled, so a held request produces a single step.
    assign mstep   = step_i && !stepReq_q && !en_i;
    assign advance = tick || mstep;

    // Next position with explicit compare-and-wrap in both directions, so the
    // index can never leave 0..NUM_POS-1.
    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (advance) begin
            if (dir_i == DIR_REV) begin
                if (pos_q == '0) begin
                    pos_d  = LAST_POS;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - POS_W'(1);
                end
            end else begin
                if (pos_q == LAST_POS) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
        end
    end

    // Position, edge-detector history and status strobes, all registered so
    // that no input reaches an output combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q       <= '0;
            stepReq_q   <= 1'b0;
            stepPulse_q <= 1'b0;
            wrapPulse_q <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            stepReq_q   <= step_i;
            stepPulse_q <= advance;
            wrapPulse_q <= wrap_d;
        end
    end

    assign pos_o  = pos_q;
    assign step_o = stepPulse_q;
    assign wrap_o = wrapPulse_q;

endmodule : spin_pos_sequencer

// File: tb/tb_spin_pos_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spin_pos_sequencer
//   Directed bench for the spinner sequencer with BASE_DIV=8, NUM_POS=6.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   checked at the same point, after the registers have settled.
// ----------------------------------------------------------------------------
module tb_spin_pos_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] speed;
    logic       stepIn;
    logic [2:0] pos;
    logic       stepOut;
    logic       wrapOut;

    int errors = 0;
    int checks = 0;

    spin_pos_sequencer #(
        .NUM_POS  (6),
        .DIV_W    (20),
        .BASE_DIV (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .dir_i   (dir),
        .speed_i (speed),
        .step_i  (stepIn),
        .pos_o   (pos),
        .step_o  (stepOut),
        .wrap_o  (wrapOut)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sets all inputs in one go.
    task automatic applyStimulus(input logic r, input logic e, input logic d,
                                 input logic [1:0] s, input logic st);
        rst    = r;
        en     = e;
        dir    = d;
        speed  = s;
        stepIn = st;
    endtask

    // Advances n rising edges and returns 1 unit after the last one.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compares all three outputs against expected values.
    task automatic checkOutput(input string tag, input logic [2:0] expPos,
                               input logic expStep, input logic expWrap);
        checks++;
        assert (pos === expPos) else begin
            errors++;
            $error("[TB] FAIL %s pos_o: observed %0d expected %0d", tag, pos, expPos);
        end
        checks++;
        assert (stepOut === expStep) else begin
            errors++;
            $error("[TB] FAIL %s step_o: observed %0b expected %0b", tag, stepOut, expStep);
        end
        checks++;
        assert (wrapOut === expWrap) else begin
            errors++;
            $error("[TB] FAIL %s wrap_o: observed %0b expected %0b", tag, wrapOut, expWrap);
        end
    endtask

    initial begin
        logic [2:0] expPos;

        // Reset with arbitrary inputs active.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
        cycles(2);
        checkOutput("reset", 3'd0, 1'b0, 1'b0);

        // Release reset, idle one cycle with en low so the counter reloads to 7.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycles(1);
        checkOutput("idle", 3'd0, 1'b0, 1'b0);

        // Forward free-running: a step every 8 edges, wrap only on 5->0.
        en = 1'b1;
        expPos = 3'd0;
        for (int k = 0; k < 6; k++) begin
            cycles(7);
            checkOutput("fwd_wait", expPos, 1'b0, 1'b0);
            expPos = (expPos == 3'd5) ? 3'd0 : expPos + 3'd1;
            cycles(1);
            checkOutput("fwd_step", expPos, 1'b1, (expPos == 3'd0));
        end

        // Reverse from 0: wraps to 5, then 4 without wrap.
        dir = 1'b1;
        cycles(8);
        checkOutput("rev_wrap", 3'd5, 1'b1, 1'b1);
        cycles(8);
        checkOutput("rev_step", 3'd4, 1'b1, 1'b0);

        // Speed 3 takes effect after the current 8-cycle count completes.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
        cycles(7);
        checkOutput("spd3_pending", 3'd4, 1'b0, 1'b0);
        cycles(1);
        checkOutput("spd3_first", 3'd5, 1'b1, 1'b0);
        cycles(1);
        checkOutput("spd3_wrap", 3'd0, 1'b1, 1'b1);
        cycles(1);
        checkOutput("spd3_p1", 3'd1, 1'b1, 1'b0);
        cycles(1);
        checkOutput("spd3_p2", 3'd2, 1'b1, 1'b0);

        // Switch to speed 1: the pending period-1 count still ticks, then 4-cycle steps.
        speed = 2'd1;
        cycles(1);
        checkOutput("spd1_finish", 3'd3, 1'b1, 1'b0);
        cycles(3);
        checkOutput("spd1_wait", 3'd3, 1'b0, 1'b0);
        cycles(1);
        checkOutput("spd1_step", 3'd4, 1'b1, 1'b0);

        // Manual mode: step_i held for 5 cycles gives exactly one step.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        cycles(1);
        checkOutput("man_step", 3'd5, 1'b1, 1'b0);
        cycles(1);
        checkOutput("man_hold1", 3'd5, 1'b0, 1'b0);
        cycles(3);
        checkOutput("man_hold4", 3'd5, 1'b0, 1'b0);
        stepIn = 1'b0;
        cycles(1);
        checkOutput("man_release", 3'd5, 1'b0, 1'b0);

        // Enabled with step_i toggling: only the prescaler advances.
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            stepIn = ~stepIn;
            cycles(1);
            checkOutput("en_toggle", 3'd5, 1'b0, 1'b0);
        end
        stepIn = 1'b0;
        cycles(1);
        checkOutput("en_tick_wrap", 3'd0, 1'b1, 1'b1);

        // Run to position 3, then reset mid-count.
        cycles(24);
        checkOutput("run_to3", 3'd3, 1'b1, 1'b0);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        checkOutput("mid_reset", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cycles(7);
        checkOutput("post_rst_wait", 3'd0, 1'b0, 1'b0);
        cycles(1);
        checkOutput("post_rst_step", 3'd1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spin_pos_sequencer
